core2axi_req_arbiter: RTL and testbench

- Shares one core-side req/gnt/rvalid port between NB_MASTERS requesters, e.g. the instruction fetch and the LSU. That port feeds the single core-to-AXI bridge.
- Arbitration is round-robin with the selection held until grant, so the downstream address and data stay stable.
- Grant owners are tracked in an in-order FIFO, so each rvalid returns to the master that issued the request.

---
 rtl/core2axi_req_arbiter.sv | 138 +++++++++++++
 tb/tb_core2axi_req_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core2axi_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : core2axi_req_arbiter
// Purpose  : Round-robin share of one core-side req/gnt/rvalid port between
//            several masters, with an in-order owner FIFO routing responses.
// Revision : 1.0 - initial release
// ============================================================================
module core2axi_req_arbiter #(
    parameter int NB_MASTERS      = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NB_MASTERS-1:0]          m_req_i,
    output logic [NB_MASTERS-1:0]          m_gnt_o,
    output logic [NB_MASTERS-1:0]          m_rvalid_o,
    input  logic [NB_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NB_MASTERS-1:0]          m_we_i,
    input  logic [NB_MASTERS*4-1:0]        m_be_i,
    input  logic [NB_MASTERS*32-1:0]       m_wdata_i,
    output logic [31:0]                    m_rdata_o,
    output logic                           s_req_o,
    input  logic                           s_gnt_i,
    input  logic                           s_rvalid_i,
    output logic [ADDR_WIDTH-1:0]          s_addr_o,
    output logic                           s_we_o,
    output logic [3:0]                     s_be_o,
    output logic [31:0]                    s_wdata_o,
    input  logic [31:0]                    s_rdata_i,
    output logic                           err_rvalid_o
);

    localparam int c_IDX_W = $clog2(NB_MASTERS);
    localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W-1:0] r_lock_idx;
    logic               r_locked;
    logic [c_IDX_W-1:0] r_owner [MAX_OUTSTANDING];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_err;

    logic [c_IDX_W-1:0] w_rr_winner;
    logic [c_IDX_W-1:0] w_winner;
    logic [c_IDX_W-1:0] w_sel;
    logic [c_IDX_W-1:0] w_head;
    logic [c_IDX_W-1:0] w_rr_next;
    logic               w_any_req;
    logic               w_not_full;
    logic               w_grant;
    logic               w_pop;

    always_comb begin
        logic [c_IDX_W-1:0] v_cand;
        logic               v_found;
        w_rr_winner = '0;
        v_found     = 1'b0;
        v_cand      = '0;
        for (int i = 0; i < NB_MASTERS; i++) begin
            v_cand = c_IDX_W'((int'(r_rr_ptr) + i) % NB_MASTERS);
            if (!v_found && m_req_i[v_cand]) begin
                w_rr_winner = v_cand;
                v_found     = 1'b1;
            end
        end
    end

    // A held selection only stays requested while its owner keeps req high;
    // a dropped locked request yields one idle cycle before re-arbitration.
    assign w_winner   = r_locked ? r_lock_idx : w_rr_winner;
    assign w_any_req  = r_locked ? m_req_i[r_lock_idx] : (|m_req_i);
    assign w_not_full = (r_count < c_CNT_W'(MAX_OUTSTANDING));
    assign w_sel      = w_any_req ? w_winner : '0;

    assign s_req_o   = w_any_req & w_not_full;
    assign s_addr_o  = m_addr_i[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_we_o    = m_we_i[w_sel];
    assign s_be_o    = m_be_i[w_sel*4 +: 4];
    assign s_wdata_o = m_wdata_i[w_sel*32 +: 32];
    assign m_rdata_o = s_rdata_i;

    assign w_grant   = s_req_o & s_gnt_i;
    assign w_pop     = s_rvalid_i & (r_count != '0);
    assign w_head    = r_owner[r_rptr];
    assign w_rr_next = (w_winner == c_IDX_W'(NB_MASTERS - 1)) ? '0 : w_winner + c_IDX_W'(1);

    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        if (w_grant) m_gnt_o[w_winner] = 1'b1;
        if (w_pop)   m_rvalid_o[w_head] = 1'b1;
    end

    assign err_rvalid_o = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
            r_locked   <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) r_owner[i] <= '0;
        end else begin
            if (s_req_o && !s_gnt_i) begin
                r_locked   <= 1'b1;
                r_lock_idx <= w_winner;
            end else if (w_grant || (r_locked && !m_req_i[r_lock_idx])) begin
                r_locked <= 1'b0;
            end

            if (w_grant) begin
                r_owner[r_wptr] <= w_winner;
                r_wptr          <= (r_wptr == c_PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_wptr + c_PTR_W'(1);
                r_rr_ptr        <= w_rr_next;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_rptr + c_PTR_W'(1);
            end

            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (s_rvalid_i && (r_count == '0)) r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core2axi_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_core2axi_req_arbiter
// Purpose  : Directed self-checking bench for core2axi_req_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core2axi_req_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  m_req_i;
    logic [1:0]  m_gnt_o;
    logic [1:0]  m_rvalid_o;
    logic [63:0] m_addr_i;
    logic [1:0]  m_we_i;
    logic [7:0]  m_be_i;
    logic [63:0] m_wdata_i;
    logic [31:0] m_rdata_o;
    logic        s_req_o;
    logic        s_gnt_i;
    logic        s_rvalid_i;
    logic [31:0] s_addr_o;
    logic        s_we_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_wdata_o;
    logic [31:0] s_rdata_i;
    logic        err_rvalid_o;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] c_ADDR0  = 32'h1000_0004;
    localparam logic [31:0] c_ADDR1  = 32'h2000_0008;
    localparam logic [31:0] c_WDATA0 = 32'hAAAA_0000;
    localparam logic [31:0] c_WDATA1 = 32'hBBBB_0001;

    core2axi_req_arbiter #(
        .NB_MASTERS(2), .ADDR_WIDTH(32), .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
        .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
        .m_wdata_i(m_wdata_i), .m_rdata_o(m_rdata_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
        .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
        .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i),
        .err_rvalid_o(err_rvalid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni     = 1'b0;
        m_req_i    = 2'b00;
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b0;
        s_rdata_i  = '0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni     = 1'b0;
        m_req_i    = 2'b00;
        s_gnt_i    = 1'b1;
        s_rvalid_i = 1'b1;
        s_rdata_i  = 32'h1234_5678;
        @(negedge clk_i);
        n_checks++;
        if (m_gnt_o !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", m_gnt_o); end
        n_checks++;
        if (m_rvalid_o !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 00", m_rvalid_o); end
        n_checks++;
        if (err_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_rvalid_o); end
        n_checks++;
        if (s_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_sreq: got %b expected 0", s_req_o); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        m_req_i = 2'b01;
        s_gnt_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (m_gnt_o !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b expected 01", m_gnt_o); end
        n_checks++;
        if (s_addr_o !== c_ADDR0) begin n_fail++; $display("FAIL single_addr: got %h expected %h", s_addr_o, c_ADDR0); end
        n_checks++;
        if (s_we_o !== 1'b0 || s_be_o !== 4'h3) begin n_fail++; $display("FAIL single_we_be: got %b/%h expected 0/3", s_we_o, s_be_o); end
        tick();
        m_req_i = 2'b00;
        s_gnt_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (m_rvalid_o !== 2'b00) begin n_fail++; $display("FAIL single_early_rvalid: got %b expected 00", m_rvalid_o); end
        tick();
        s_rvalid_i = 1'b1;
        s_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk_i);
        n_checks++;
        if (m_rvalid_o !== 2'b01) begin n_fail++; $display("FAIL single_rvalid: got %b expected 01", m_rvalid_o); end
        n_checks++;
        if (m_rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rdata: got %h expected deadbeef", m_rdata_o); end
        tick();
        s_rvalid_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (err_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b expected 0", err_rvalid_o); end
    endtask

    task automatic test_fairness();
        logic [1:0] req_t [5] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
        logic       rv_t  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] gnt_e [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        logic [1:0] rv_e  [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        s_gnt_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            m_req_i    = req_t[c];
            s_rvalid_i = rv_t[c];
            @(negedge clk_i);
            n_checks++;
            if (m_gnt_o !== gnt_e[c]) begin n_fail++; $display("FAIL fair_gnt[%0d]: got %b expected %b", c, m_gnt_o, gnt_e[c]); end
            n_checks++;
            if (m_rvalid_o !== rv_e[c]) begin n_fail++; $display("FAIL fair_rvalid[%0d]: got %b expected %b", c, m_rvalid_o, rv_e[c]); end
            if (gnt_e[c] != 2'b00) begin
                n_checks++;
                if (s_wdata_o !== ((gnt_e[c] == 2'b01) ? c_WDATA0 : c_WDATA1) || s_we_o !== gnt_e[c][1]) begin
                    n_fail++;
                    $display("FAIL fair_data[%0d]: got %h/%b for grant %b", c, s_wdata_o, s_we_o, gnt_e[c]);
                end
            end
            tick();
        end
        s_rvalid_i = 1'b0;
        s_gnt_i    = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        // Move the round-robin pointer to master1 so the lock is what keeps master0.
        m_req_i = 2'b01;
        s_gnt_i = 1'b1;
        tick();
        m_req_i    = 2'b00;
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b1;
        tick();
        s_rvalid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            m_req_i = (c == 0) ? 2'b01 : 2'b11;
            s_gnt_i = (c == 3);
            @(negedge clk_i);
            n_checks++;
            if (s_addr_o !== c_ADDR0) begin n_fail++; $display("FAIL lock_addr[%0d]: got %h expected %h", c, s_addr_o, c_ADDR0); end
            n_checks++;
            if (m_gnt_o !== ((c == 3) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL lock_gnt[%0d]: got %b expected %b", c, m_gnt_o, (c == 3) ? 2'b01 : 2'b00); end
            tick();
        end
        m_req_i = 2'b11;
        s_gnt_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (m_gnt_o !== 2'b10 || s_addr_o !== c_ADDR1) begin n_fail++; $display("FAIL lock_next: got %b/%h expected 10/%h", m_gnt_o, s_addr_o, c_ADDR1); end
        tick();
        m_req_i    = 2'b00;
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (m_rvalid_o !== 2'b01) begin n_fail++; $display("FAIL lock_rv0: got %b expected 01", m_rvalid_o); end
        tick();
        @(negedge clk_i);
        n_checks++;
        if (m_rvalid_o !== 2'b10) begin n_fail++; $display("FAIL lock_rv1: got %b expected 10", m_rvalid_o); end
        tick();
        s_rvalid_i = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        m_req_i = 2'b01;
        s_gnt_i = 1'b1;
        tick();
        tick();
        m_req_i = 2'b10;
        for (int c = 0; c < 2; c++) begin
            s_rvalid_i = (c == 1);
            @(negedge clk_i);
            n_checks++;
            if (s_req_o !== 1'b0 || m_gnt_o !== 2'b00) begin n_fail++; $display("FAIL full_block[%0d]: got req %b gnt %b expected 0/00", c, s_req_o, m_gnt_o); end
            if (c == 1) begin
                n_checks++;
                if (m_rvalid_o !== 2'b01) begin n_fail++; $display("FAIL full_pop: got %b expected 01", m_rvalid_o); end
            end
            tick();
        end
        s_rvalid_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (s_req_o !== 1'b1 || m_gnt_o !== 2'b10) begin n_fail++; $display("FAIL full_resume: got req %b gnt %b expected 1/10", s_req_o, m_gnt_o); end
        tick();
        m_req_i    = 2'b00;
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (m_rvalid_o !== 2'b01) begin n_fail++; $display("FAIL full_drain0: got %b expected 01", m_rvalid_o); end
        tick();
        @(negedge clk_i);
        n_checks++;
        if (m_rvalid_o !== 2'b10) begin n_fail++; $display("FAIL full_drain1: got %b expected 10", m_rvalid_o); end
        tick();
        s_rvalid_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (err_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL full_err: got %b expected 0", err_rvalid_o); end
    endtask

    task automatic test_spurious();
        do_reset();
        s_rvalid_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (m_rvalid_o !== 2'b00 || err_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL spur_now: got rv %b err %b expected 00/0", m_rvalid_o, err_rvalid_o); end
        tick();
        s_rvalid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            n_checks++;
            if (err_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL spur_sticky[%0d]: got %b expected 1", c, err_rvalid_o); end
            tick();
        end
        // Grant and rvalid together on an empty FIFO: the new entry is not the owner.
        do_reset();
        m_req_i    = 2'b01;
        s_gnt_i    = 1'b1;
        s_rvalid_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (m_gnt_o !== 2'b01 || m_rvalid_o !== 2'b00) begin n_fail++; $display("FAIL spur_simul: got gnt %b rv %b expected 01/00", m_gnt_o, m_rvalid_o); end
        tick();
        m_req_i = 2'b00;
        s_gnt_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (m_rvalid_o !== 2'b01 || err_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL spur_simul_next: got rv %b err %b expected 01/1", m_rvalid_o, err_rvalid_o); end
        tick();
        s_rvalid_i = 1'b0;
    endtask

    task automatic test_reset_midop();
        do_reset();
        m_req_i = 2'b10;
        s_gnt_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (m_gnt_o !== 2'b10) begin n_fail++; $display("FAIL midop_gnt1: got %b expected 10", m_gnt_o); end
        tick();
        m_req_i = 2'b01;
        tick();
        m_req_i = 2'b00;
        s_gnt_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (s_req_o !== 1'b0 || m_gnt_o !== 2'b00 || m_rvalid_o !== 2'b00) begin n_fail++; $display("FAIL midop_in_reset: got req %b gnt %b rv %b expected 0/00/00", s_req_o, m_gnt_o, m_rvalid_o); end
        tick();
        rst_ni     = 1'b1;
        s_rvalid_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (m_rvalid_o !== 2'b00) begin n_fail++; $display("FAIL midop_rvalid: got %b expected 00", m_rvalid_o); end
        tick();
        s_rvalid_i = 1'b0;
        m_req_i    = 2'b11;
        s_gnt_i    = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (err_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL midop_err: got %b expected 1", err_rvalid_o); end
        n_checks++;
        if (m_gnt_o !== 2'b01) begin n_fail++; $display("FAIL midop_rrptr: got %b expected 01", m_gnt_o); end
        tick();
        m_req_i = 2'b00;
        s_gnt_i = 1'b0;
    endtask

    initial begin
        rst_ni     = 1'b0;
        m_req_i    = 2'b00;
        m_addr_i   = {c_ADDR1, c_ADDR0};
        m_we_i     = 2'b10;
        m_be_i     = {4'hC, 4'h3};
        m_wdata_i  = {c_WDATA1, c_WDATA0};
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b0;
        s_rdata_i  = '0;
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_lock();
        test_full();
        test_spurious();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
